spart_driver: RTL

- Bus-master counterpart to the SPART's processor-side register interface; it plays the processor role.
- Programs the SPART baud divisor from a 2-bit configuration switch input.
- Then polls the status flags, reading each received character and writing it back to the transmitter (echo).
- A small internal FIFO absorbs characters that arrive while the transmitter is busy. Sits at board top level beside the SPART, replacing a soft CPU for bring-up.

---
 rtl/spart_pkg.sv | 40 ++++
 rtl/spart_driver_if.sv | 25 ++
 rtl/spart_drv_fifo.sv | 61 ++++++
 rtl/spart_driver.sv | 132 +++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spart_pkg
//  Description : Shared definitions for the SPART bus-master driver:
//                SPART register addresses, driver FSM state encoding and
//                the baud-select to divisor lookup (50 MHz, 16x oversample).
//  Revision    : 1.0  initial release
// ============================================================================
package spart_pkg;

    // SPART processor-side register map
    localparam logic [1:0] ADDR_BUF  = 2'b00;  // read: RX buffer, write: TX buffer
    localparam logic [1:0] ADDR_STAT = 2'b01;  // status, read only
    localparam logic [1:0] ADDR_DBL  = 2'b10;  // divisor low byte
    localparam logic [1:0] ADDR_DBH  = 2'b11;  // divisor high byte

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        INIT_LO = 3'd1,
        INIT_HI = 3'd2,
        IDLE    = 3'd3,
        RD_RX   = 3'd4,
        WR_TX   = 3'd5,
        HOLD    = 3'd6
    } state_t;

    // br_cfg: 00=4800, 01=9600, 10=19200, 11=38400 baud
    function automatic logic [15:0] br_divisor(input logic [1:0] cfg);
        logic [15:0] div;
        case (cfg)
            2'b00:   div = 16'h028B;
            2'b01:   div = 16'h0145;
            2'b10:   div = 16'h00A2;
            default: div = 16'h0051;
        endcase
        return div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spart_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : spart_driver_if
//  Description : Control/handshake bundle between the driver (master) and
//                the SPART register interface (slave).
//                  iocs   : chip select, one cycle per access
//                  iorw   : 1=read, 0=write
//                  ioaddr : register address
//                  rda    : receive data available
//                  tbr    : transmit buffer ready
//                The 8-bit data bus is a true tristate pin and is carried as
//                a separate inout port of the driver.
//  Revision    : 1.0  initial release
// ============================================================================
interface spart_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface
`default_nettype wire

// File: rtl/spart_drv_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spart_drv_fifo
//  Description : Circular echo buffer, 8-bit wide, QDEPTH entries.
//                Ports: clk, rst_n (sync, active-low), i_push/i_din write
//                side, i_pop/o_dout read side (o_dout shows the head),
//                o_full / o_empty status.
//                Push into a full FIFO or pop from an empty one is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module spart_drv_fifo #(
    parameter int QDEPTH = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_push,
    input  wire logic       i_pop,
    input  wire logic [7:0] i_din,
    output logic      [7:0] o_dout,
    output logic            o_full,
    output logic            o_empty
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] C_FULL_CNT = (AW+1)'(QDEPTH);

    logic [7:0]    r_mem [QDEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == C_FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr];

    // Pointers wrap naturally because QDEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define validity
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end
endmodule
`default_nettype wire

// File: rtl/spart_driver.sv
`default_nettype none
// ============================================================================
//  Module      : spart_driver
//  Description : Processor stand-in for SPART bring-up. Writes the baud
//                divisor chosen by br_cfg, then echoes every received byte
//                back to the transmitter through a small FIFO.
//                Ports: clk, rst_n (sync, active-low), br_cfg (baud select),
//                bus (iocs/iorw/ioaddr/rda/tbr), databus (tristate data),
//                q_ovf (sticky: a byte was dropped on a full FIFO).
//                All bus outputs are registered from the next-state decision.
//  Revision    : 1.0  initial release
// ============================================================================
module spart_driver
    import spart_pkg::*;
#(
    parameter int QDEPTH = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [1:0] br_cfg,
    spart_driver_if.master  bus,
    inout  wire       [7:0] databus,
    output logic            q_ovf
);
    state_t      r_state;
    logic        r_iocs;
    logic        r_iorw;
    logic [1:0]  r_ioaddr;
    logic        r_oe;
    logic [7:0]  r_wdata;
    logic [1:0]  r_br_cfg_q;
    logic        r_drop;
    logic        r_q_ovf;

    logic [15:0] w_div_new;
    logic [15:0] w_div_cur;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;

    assign w_div_new = br_divisor(br_cfg);
    assign w_div_cur = br_divisor(r_br_cfg_q);

    // The read byte is captured at the end of the RD_RX cycle itself
    assign w_push = (r_state == RD_RX) && !r_drop;
    assign w_pop  = (r_state == WR_TX);

    spart_drv_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (databus),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_iocs     <= 1'b0;
            r_iorw     <= 1'b1;
            r_ioaddr   <= ADDR_BUF;
            r_oe       <= 1'b0;
            r_wdata    <= 8'h00;
            r_br_cfg_q <= 2'b00;
            r_drop     <= 1'b0;
            r_q_ovf    <= 1'b0;
        end else begin
            // Default: bus released, read direction
            r_iocs   <= 1'b0;
            r_iorw   <= 1'b1;
            r_ioaddr <= ADDR_BUF;
            r_oe     <= 1'b0;

            if (r_state == RD_RX && r_drop) r_q_ovf <= 1'b1;

            case (r_state)
                BOOT, IDLE: begin
                    if (r_state == BOOT || br_cfg != r_br_cfg_q) begin
                        r_state    <= INIT_LO;
                        r_iocs     <= 1'b1;
                        r_iorw     <= 1'b0;
                        r_ioaddr   <= ADDR_DBL;
                        r_oe       <= 1'b1;
                        r_wdata    <= w_div_new[7:0];
                        r_br_cfg_q <= br_cfg;
                    end else if (bus.rda && !w_full) begin
                        r_state <= RD_RX;
                        r_iocs  <= 1'b1;
                        r_drop  <= 1'b0;
                    end else if (bus.tbr && !w_empty) begin
                        r_state <= WR_TX;
                        r_iocs  <= 1'b1;
                        r_iorw  <= 1'b0;
                        r_oe    <= 1'b1;
                        r_wdata <= w_head;
                    end else if (bus.rda) begin
                        // Still read to clear the SPART's rda, but discard
                        r_state <= RD_RX;
                        r_iocs  <= 1'b1;
                        r_drop  <= 1'b1;
                    end
                end
                INIT_LO: begin
                    r_state  <= INIT_HI;
                    r_iocs   <= 1'b1;
                    r_iorw   <= 1'b0;
                    r_ioaddr <= ADDR_DBH;
                    r_oe     <= 1'b1;
                    r_wdata  <= w_div_cur[15:8];
                end
                INIT_HI, RD_RX, WR_TX: r_state <= HOLD;
                // Gap cycle so the SPART's registered flags settle
                HOLD:    r_state <= IDLE;
                default: r_state <= BOOT;
            endcase
        end
    end

    assign bus.iocs   = r_iocs;
    assign bus.iorw   = r_iorw;
    assign bus.ioaddr = r_ioaddr;
    assign databus    = r_oe ? r_wdata : 8'hzz;
    assign q_ovf      = r_q_ovf;
endmodule
`default_nettype wire
